// File: rtl/data_memory_mmio.sv
// -----------------------------------------------------------------------------
// data_memory_mmio
//
// Data-side memory system for the single-cycle Armv4 core. It sits directly on
// the core's data port. A load returns data in the same cycle. A store commits
// on the next rising clock edge.
//
// Address map:
//   address[31:16] == MMIO_PAGE  -> peripheral page, register offset address[7:0]
//   anything else                -> data RAM, word index address[log2(RAM_WORDS)+1:2]
//                                   (the upper bits alias, so the RAM wraps)
//   address[1:0] is ignored everywhere because every access is a whole word.
//
// Peripheral registers:
//   0x00 CYCLE  RO  free-running cycle counter
//   0x04 LOAD   RW  timer reload value
//   0x08 COUNT  RO  current timer count
//   0x0C CTRL   RW  bit0 enable, bit1 auto_reload, bit2 irq_en
//   0x10 STATUS W1C bit0 expired (sticky)
//   0x14 GPIO   RW  bits[7:0] drive gpio_out
//
// Ports:
//   clock         single clock; all state updates on the rising edge
//   reset         asynchronous active-low reset (the RAM is not reset)
//   write_memory  store strobe from the core
//   address       byte address (the core's ALU result)
//   write_data    store data
//   read_data     load data, combinational from address and current state
//   timer_irq     registered interrupt: expired AND irq_en
//   gpio_out      registered GPIO value
// -----------------------------------------------------------------------------
module data_memory_mmio #(
    parameter int          RAM_WORDS = 64,
    parameter logic [15:0] MMIO_PAGE = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_memory,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        timer_irq,
    output logic [7:0]  gpio_out
);

    localparam int IDX_W = $clog2(RAM_WORDS);

    localparam logic [7:0] OFF_CYCLE  = 8'h00;
    localparam logic [7:0] OFF_LOAD   = 8'h04;
    localparam logic [7:0] OFF_COUNT  = 8'h08;
    localparam logic [7:0] OFF_CTRL   = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;
    localparam logic [7:0] OFF_GPIO   = 8'h14;

    // CTRL bit positions
    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    typedef enum logic {
        T_IDLE    = 1'b0,
        T_RUNNING = 1'b1
    } timer_state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic             mmio_sel;
    logic [7:0]       offset;
    logic [IDX_W-1:0] ram_idx;
    logic             mmio_wr;
    logic             wr_load;
    logic             wr_ctrl;
    logic             wr_status;
    logic             wr_gpio;

    assign mmio_sel  = (address[31:16] == MMIO_PAGE);
    assign offset    = address[7:0];
    assign ram_idx   = address[IDX_W+1:2];
    assign mmio_wr   = write_memory && mmio_sel;
    assign wr_load   = mmio_wr && (offset == OFF_LOAD);
    assign wr_ctrl   = mmio_wr && (offset == OFF_CTRL);
    assign wr_status = mmio_wr && (offset == OFF_STATUS);
    assign wr_gpio   = mmio_wr && (offset == OFF_GPIO);

    // Which address bits are decoded depends on RAM_WORDS. Fold the whole
    // bus into one dummy net so that the bits left unused do not look like
    // an oversight.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address;

    // ------------------------------------------------------------------
    // Data RAM: synchronous write, asynchronous read, no reset.
    // A read and a write to the same word in one cycle therefore return
    // the old word.
    // ------------------------------------------------------------------
    logic [31:0] ram_q [RAM_WORDS];

    always_ff @(posedge clock) begin
        if (write_memory && !mmio_sel) begin
            ram_q[ram_idx] <= write_data;
        end
    end

    // ------------------------------------------------------------------
    // Peripheral state
    // ------------------------------------------------------------------
    timer_state_t state_q,   state_d;
    logic [31:0]  cycle_q,   cycle_d;
    logic [31:0]  load_q,    load_d;
    logic [31:0]  count_q,   count_d;
    logic [2:0]   ctrl_q,    ctrl_d;
    logic         expired_q, expired_d;
    logic [7:0]   gpio_q,    gpio_d;
    logic         irq_q,     irq_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= T_IDLE;
            cycle_q   <= 32'd0;
            load_q    <= 32'd0;
            count_q   <= 32'd0;
            ctrl_q    <= 3'd0;
            expired_q <= 1'b0;
            gpio_q    <= 8'd0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            load_q    <= load_d;
            count_q   <= count_d;
            ctrl_q    <= ctrl_d;
            expired_q <= expired_d;
            gpio_q    <= gpio_d;
            irq_q     <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: register writes first, then the timer FSM.
    // The FSM runs last so that its overrides win:
    //   - an expiry sets expired even when a STATUS clear lands in the
    //     same cycle;
    //   - a one-shot expiry clears CTRL.enable.
    // A disabling CTRL write pre-empts the expiry branch entirely, so no
    // expiry is recorded in that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q + 32'd1;
        load_d    = load_q;
        count_d   = count_q;
        ctrl_d    = ctrl_q;
        expired_d = expired_q;
        gpio_d    = gpio_q;

        if (wr_load) begin
            load_d = write_data;
        end
        if (wr_ctrl) begin
            ctrl_d = write_data[2:0];
        end
        if (wr_gpio) begin
            gpio_d = write_data[7:0];
        end
        if (wr_status && write_data[0]) begin
            expired_d = 1'b0;
        end

        case (state_q)
            T_IDLE: begin
                if (wr_ctrl && write_data[CTRL_EN]) begin
                    state_d = T_RUNNING;
                    // Reload from the pre-edge LOAD value. A LOAD write in
                    // the same cycle applies only to later reloads.
                    count_d = load_q;
                end
            end
            T_RUNNING: begin
                if (wr_ctrl && !write_data[CTRL_EN]) begin
                    state_d = T_IDLE;
                end else if (count_q != 32'd0) begin
                    count_d = count_q - 32'd1;
                end else begin
                    expired_d = 1'b1;
                    if (ctrl_q[CTRL_AR]) begin
                        count_d = load_q;
                    end else begin
                        ctrl_d[CTRL_EN] = 1'b0;
                        state_d         = T_IDLE;
                    end
                end
            end
            default: begin
                state_d = T_IDLE;
            end
        endcase

        // Taken from the next-state values so the interrupt is visible in
        // the same cycle that STATUS first reads 1.
        irq_d = expired_d && ctrl_d[CTRL_IE];
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] mmio_rdata;

    always_comb begin
        mmio_rdata = 32'd0;
        case (offset)
            OFF_CYCLE:  mmio_rdata = cycle_q;
            OFF_LOAD:   mmio_rdata = load_q;
            OFF_COUNT:  mmio_rdata = count_q;
            OFF_CTRL:   mmio_rdata = {29'd0, ctrl_q};
            OFF_STATUS: mmio_rdata = {31'd0, expired_q};
            OFF_GPIO:   mmio_rdata = {24'd0, gpio_q};
            default:    mmio_rdata = 32'd0;
        endcase
    end

    assign read_data = mmio_sel ? mmio_rdata : ram_q[ram_idx];
    assign timer_irq = irq_q;
    assign gpio_out  = gpio_q;

endmodule

// File: doc/data_memory_mmio.md
# data_memory_mmio

Data-side memory system for the single-cycle Armv4 core. It sits directly downstream of the core's data port: it takes the ALU-computed address, the store data and the write strobe, and returns load data within the same cycle. It contains a word-addressed data RAM and a small memory-mapped peripheral page with:
- a free-running cycle counter,
- a down-counting timer with interrupt,
- an 8-bit GPIO output register.

## Interface
- RAM_WORDS, 64: data RAM depth in 32-bit words; power of two, 16..1024.
- MMIO_PAGE, 16'hFFFF: value of address[31:16] that selects the peripheral page.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- write_memory  in  1  store strobe from core.
- address  in  32  byte address, driven by core ALU_result.
- write_data  in  32  store data from core.
- read_data  out  32  load data to core; combinational from address.
- timer_irq  out  1  registered; high while STATUS.expired and CTRL.irq_en.
- gpio_out  out  8  registered GPIO value.

## Operation
- Decode:
  - address[31:16] == MMIO_PAGE selects MMIO.
  - Otherwise RAM, word index = address[log2(RAM_WORDS)+1:2]; upper bits are ignored (aliasing/wrap).
  - address[1:0] are ignored everywhere (word access only).
- RAM:
  - Write on rising edge when write_memory=1.
  - Read is asynchronous.
  - Not reset; contents are undefined after power-up.
- MMIO registers, at offset address[7:0]. Any other offset reads 0 and ignores writes.
  - 0x00 CYCLE (RO): 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF -> 0.
  - 0x04 LOAD (RW): timer reload value, 32 bits.
  - 0x08 COUNT (RO): current timer count.
  - 0x0C CTRL (RW): bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x10 STATUS: bit0 expired, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
  - 0x14 GPIO (RW): bits[7:0] drive gpio_out; upper bits read 0.
- Timer FSM, two states:
  - IDLE -> RUNNING: CTRL write with enable=1 while in IDLE. COUNT <= LOAD at that edge.
  - RUNNING, COUNT != 0: COUNT decrements by 1 each cycle.
  - RUNNING, COUNT == 0 with auto_reload=1: expired <= 1, COUNT <= LOAD, stay RUNNING. Period is LOAD+1 cycles.
  - RUNNING, COUNT == 0 with auto_reload=0: expired <= 1, CTRL.enable <= 0, go to IDLE; COUNT holds 0.
  - RUNNING -> IDLE: CTRL write with enable=0. COUNT holds its value.
  - CTRL write with enable=1 while RUNNING: updates auto_reload/irq_en only; no reload.
- LOAD writes while RUNNING take effect at the next reload only.
- Simultaneous events:
  - Expiry and STATUS clear-write in the same cycle: expired stays 1 (set wins).
  - Expiry and a CTRL write disabling the timer in the same cycle: the disable wins; no expiry is recorded.

## Timing
- Load latency 0: read_data is valid in the same cycle the address is presented. RAM and MMIO reads return pre-edge values.
- Store latency 1: the written value is visible on read_data from the cycle after the write edge.
- A read and write to the same address in one cycle returns the old value.
- CYCLE reads 0 in the first cycle after reset deasserts and N in cycle N.
- timer_irq is registered from the next-state values: it asserts in the cycle after the edge on which expired is set, concurrent with STATUS reading 1.
- Reset (asynchronous, mid-operation included) forces immediately:
  - CYCLE, LOAD, COUNT, CTRL, STATUS, GPIO = 0.
  - FSM = IDLE.
  - timer_irq = 0, gpio_out = 0.
  - MMIO read_data = 0.
  - RAM contents are unaffected.
- No stalls and no handshake; every access completes in one cycle.

## Test plan
- RAM store/load: write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000013 -> both 0xDEADBEEF. With RAM_WORDS=64, read 0x00000110 -> 0xDEADBEEF (alias).
- Cycle counter: release reset, read 0xFFFF0000 in cycles 0, 1, 10 -> 0, 1, 10. Force near-wrap via long run or a bench `force` -> 0xFFFFFFFF followed by 0.
- One-shot timer:
  - Setup: LOAD=3, write CTRL=0x5.
  - COUNT reads 3, 2, 1, 0 on successive cycles.
  - Next edge: STATUS=1, CTRL.enable=0, timer_irq=1 one cycle after that edge.
  - Write STATUS=1 -> irq drops the following cycle.
- Auto-reload: LOAD=2, CTRL=0x3 -> expired sets every 3 cycles. Clear-write coinciding with an expiry edge -> STATUS remains 1.
- GPIO and unmapped offsets: write 0x1A5 to 0xFFFF0014 -> gpio_out=0xA5, read 0x000000A5. Write to 0xFFFF0040 -> no state change; read returns 0.
- Reset mid-count: with the timer RUNNING at COUNT=5 and GPIO=0xFF, assert reset asynchronously between edges -> COUNT, GPIO, timer_irq and gpio_out go to 0 immediately; previously written RAM data is still readable after release.
